// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the REG_BUS initiator.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RSP     = 3'd4
    } rbm_state_t;

    localparam logic [31:0] RBM_TO_RDAT = 32'hDEADBEEF;

endpackage

// File: rtl/reg_bus_master.sv
// REG_BUS initiator: one register command at a time in, one response out.
// Valid/ready: a transfer happens on the rising CLK edge where VLD and RDY are both 1.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VLD,
    output logic              CMD_RDY,
    input  logic              CMD_WR,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [31:0]       CMD_WDAT,
    output logic              RSP_VLD,
    input  logic              RSP_RDY,
    output logic              RSP_ERR,
    output logic [31:0]       RSP_RDAT,
    output logic              BUS_WREN,
    output logic [ADDR_W-1:0] BUS_WADR,
    output logic [31:0]       BUS_WDAT,
    output logic              BUS_RDEN,
    output logic [ADDR_W-1:0] BUS_RADR,
    input  logic [31:0]       BUS_RDAT,
    input  logic              BUS_RVLD,
    output logic [15:0]       TO_CNT,
    output logic [2:0]        DBG_STATE
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);
    localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYC - 1);

    rbm_state_t  state;
    logic [15:0] timer;

    assign DBG_STATE = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            timer    <= '0;
            CMD_RDY  <= 1'b0;
            RSP_VLD  <= 1'b0;
            RSP_ERR  <= 1'b0;
            RSP_RDAT <= '0;
            BUS_WREN <= 1'b0;
            BUS_WADR <= '0;
            BUS_WDAT <= '0;
            BUS_RDEN <= 1'b0;
            BUS_RADR <= '0;
            TO_CNT   <= '0;
        end else begin
            BUS_WREN <= 1'b0;
            BUS_RDEN <= 1'b0;
            case (state)
                IDLE: begin
                    if (CMD_VLD && CMD_RDY) begin
                        CMD_RDY <= 1'b0;
                        // Bus address/data only move when their strobe fires.
                        if (CMD_WR) begin
                            BUS_WREN <= 1'b1;
                            BUS_WADR <= CMD_ADDR & ADDR_MASK;
                            BUS_WDAT <= CMD_WDAT;
                            state    <= WR;
                        end else begin
                            BUS_RDEN <= 1'b1;
                            BUS_RADR <= CMD_ADDR & ADDR_MASK;
                            state    <= RD_REQ;
                        end
                    end else begin
                        CMD_RDY <= 1'b1;
                    end
                end
                WR: begin
                    RSP_VLD  <= 1'b1;
                    RSP_ERR  <= 1'b0;
                    RSP_RDAT <= '0;
                    state    <= RSP;
                end
                RD_REQ: begin
                    timer <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    // A data beat arriving on the last timeout cycle still counts.
                    if (BUS_RVLD) begin
                        RSP_VLD  <= 1'b1;
                        RSP_ERR  <= 1'b0;
                        RSP_RDAT <= BUS_RDAT;
                        state    <= RSP;
                    end else if (timer == TO_LAST) begin
                        RSP_VLD  <= 1'b1;
                        RSP_ERR  <= 1'b1;
                        RSP_RDAT <= RBM_TO_RDAT;
                        state    <= RSP;
                        if (TO_CNT != 16'hFFFF) begin
                            TO_CNT <= TO_CNT + 16'd1;
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RSP: begin
                    if (RSP_RDY) begin
                        RSP_VLD <= 1'b0;
                        CMD_RDY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
